fetch_ctrl: RTL and testbench

Fetch sequencer for the F stage. It owns the program counter and runs a one-outstanding request/ready handshake with a variable-latency instruction memory. It delivers fetched instructions to decode through a one-entry output register with valid/stall flow control. It applies redirects (jr, branch, jump targets resolved in D), including redirects that arrive while a memory transaction is in flight.

---
 rtl/fetch_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// F-stage fetch sequencer: owns the PC, runs a one-outstanding request/ready
// handshake with instruction memory and feeds decode through a one-entry slot.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             Reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             fd_valid,
    output logic [31:0]      fd_instr,
    output logic [31:0]      fd_pc,
    input  logic             fd_stall,
    input  logic             redir_valid,
    input  logic [31:0]      redir_target,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic             r_req;
    logic             r_fd_valid;
    logic [31:0]      r_fd_instr;
    logic [31:0]      r_fd_pc;
    logic             r_squash;
    logic [31:0]      r_pend_pc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_slot_free;
    logic [31:0]      w_target;

    assign w_slot_free = !r_fd_valid || !fd_stall;
    assign w_target    = {redir_target[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_fd_valid <= 1'b0;
            r_fd_instr <= 32'h0;
            r_fd_pc    <= 32'h0;
            r_squash   <= 1'b0;
            r_pend_pc  <= 32'h0;
            r_cnt      <= '0;
        end else begin
            // Flush beats consumption; a delivery below overrides both.
            if (redir_valid)
                r_fd_valid <= 1'b0;
            else if (r_fd_valid && !fd_stall)
                r_fd_valid <= 1'b0;

            case (r_state)
                IDLE, HOLD: begin
                    if (redir_valid) begin
                        r_pc    <= w_target;
                        r_state <= WAIT;
                        r_req   <= 1'b1;
                    end else if (w_slot_free) begin
                        r_state <= WAIT;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= HOLD;
                        r_req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_ready) begin
                        r_squash <= 1'b0;
                        if (redir_valid) begin
                            r_pc    <= w_target;
                            r_state <= WAIT;
                            r_req   <= 1'b1;
                        end else if (r_squash) begin
                            r_pc    <= r_pend_pc;
                            r_state <= w_slot_free ? WAIT : HOLD;
                            r_req   <= w_slot_free;
                        end else begin
                            r_fd_valid <= 1'b1;
                            r_fd_instr <= imem_rdata;
                            r_fd_pc    <= r_pc;
                            r_pc       <= r_pc + 32'd4;
                            r_cnt      <= r_cnt + CNT_W'(1);
                            // Slot is now full; next request waits for it to drain.
                            r_state    <= HOLD;
                            r_req      <= 1'b0;
                        end
                    end else if (redir_valid) begin
                        r_squash  <= 1'b1;
                        r_pend_pc <= w_target;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign fd_valid  = r_fd_valid;
    assign fd_instr  = r_fd_instr;
    assign fd_pc     = r_fd_pc;
    assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, all checked
// against a transaction-level model of the fetch stream and the decode slot.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        fd_stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic [31:0] pc;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    // Model: the slot contents, the address stream and the open transaction.
    logic        m_vld, m_txn, m_squash, m_after_rst;
    logic [31:0] m_pc, m_instr, m_cnt, m_next, m_txn_addr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_f(imem_addr);

    fetch_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk(clk), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .fd_valid(fd_valid), .fd_instr(fd_instr), .fd_pc(fd_pc),
        .fd_stall(fd_stall),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .pc(pc), .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic rv, input logic [31:0] rt,
                              input logic st, input logic rdy);
        logic dlv;
        dlv = 1'b0;
        if (rst) begin
            m_vld = 0; m_pc = 0; m_instr = 0; m_cnt = 0;
            m_next = 32'h3000; m_txn = 0; m_squash = 0; m_after_rst = 1;
        end else begin
            m_after_rst = 0;
            if (m_txn && rdy) begin
                if (!rv && !m_squash) begin
                    dlv = 1'b1;
                    m_vld = 1; m_pc = m_txn_addr; m_instr = mem_f(m_txn_addr);
                    m_cnt = m_cnt + 1; m_next = m_txn_addr + 32'd4;
                end
                m_txn = 0; m_squash = 0;
            end else if (m_txn && rv) begin
                m_squash = 1;
            end
            if (rv) begin
                m_next = rt & ~32'd3;
                m_vld = 0;
            end else if (!dlv && m_vld && !st) begin
                m_vld = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("fd_valid", {31'b0, fd_valid}, {31'b0, m_vld});
        chk("fd_pc", fd_pc, m_pc);
        chk("fd_instr", fd_instr, m_instr);
        chk("fetch_cnt", fetch_cnt, m_cnt);
        chk("pc_is_addr", pc, imem_addr);
        // A request is outstanding exactly when the slot is empty, except
        // for the single idle cycle following reset.
        chk("imem_req", {31'b0, imem_req}, {31'b0, (!m_after_rst && !m_vld)});
        if (imem_req === 1'b1) begin
            if (!m_txn) begin
                chk("req_addr", imem_addr, m_next);
                m_txn = 1; m_txn_addr = m_next; m_squash = 0;
            end else begin
                chk("addr_stable", imem_addr, m_txn_addr);
            end
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic [31:0] rt,
                        input logic st, input logic rdy);
        Reset = rst; redir_valid = rv; redir_target = rt; fd_stall = st;
        imem_ready = rdy & (imem_req === 1'b1);
        @(negedge clk);
        model_edge(rst, rv, rt, st, imem_ready);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_txn(input int lat);
        repeat (lat) step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 1);
    endtask

    initial begin
        m_vld = 0; m_txn = 0; m_squash = 0; m_after_rst = 1;
        m_pc = 0; m_instr = 0; m_cnt = 0; m_next = 32'h3000; m_txn_addr = 0;

        step(1, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("first_addr", imem_addr, 32'h3000);

        for (int k = 0; k < 3; k++) run_txn(2);
        chk("cnt_after_3", fetch_cnt, 32'd3);
        chk("third_pc", fd_pc, 32'h3008);

        repeat (5) step(0, 0, 32'h0, 1, 0);
        chk("held_req", {31'b0, imem_req}, 32'd0);
        step(0, 0, 32'h0, 0, 0);
        chk("addr_after_stall", imem_addr, 32'h300C);

        step(0, 1, 32'h3100, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 1);
        chk("squash_cnt", fetch_cnt, 32'd3);
        chk("squash_addr", imem_addr, 32'h3100);

        step(0, 1, 32'h3200, 0, 1);
        chk("redir_ready_vld", {31'b0, fd_valid}, 32'd0);
        chk("redir_ready_addr", imem_addr, 32'h3200);

        step(0, 1, 32'h3300, 0, 0);
        step(0, 1, 32'h3400, 0, 0);
        step(0, 0, 32'h0, 0, 1);
        chk("newest_wins", imem_addr, 32'h3400);
        step(0, 1, 32'h3403, 0, 1);
        chk("target_align", imem_addr, 32'h3400);

        step(0, 1, 32'hFFFF_FFFC, 0, 1);
        run_txn(0);
        step(0, 0, 32'h0, 0, 0);
        chk("pc_wrap", imem_addr, 32'h0);

        step(1, 0, 32'h0, 0, 1);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        step(0, 0, 32'h0, 0, 0);
        chk("rst_new_addr", imem_addr, 32'h3000);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) == 0),
                 $urandom,
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 99) < 35));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
